// File: rtl/sys_mem_resp.sv
// Single-word memory responder for the CVP14 core bus; one access per request level.
// Optional MEM_BOUNDS_EN: flag and suppress accesses beyond 2**DEPTH_LOG2 words instead of aliasing.
module sys_mem_resp #(
   parameter int          DEPTH_LOG2 = 10,
   parameter logic [15:0] BAD_DATA   = 16'hDEAD
) (
   input  logic        Clk1,
   input  logic        Reset,
   input  logic [15:0] Addr,
   input  logic        RD,
   input  logic        WR,
   input  logic [15:0] DataOut,
   output logic [15:0] DataIn,
   output logic        Err,
   output logic        Busy,
   output logic [15:0] RdCnt,
   output logic [15:0] WrCnt
);

   // state    | meaning
   // IDLE     | no request held; next RD or WR level starts an access
   // RD_ACT   | read done, waiting for RD to drop
   // WR_ACT   | write done, waiting for WR to drop
   // CONFLICT | RD and WR seen together; waiting for both low
   typedef enum logic [1:0] {IDLE, RD_ACT, WR_ACT, CONFLICT} state_t;

   state_t state_q, state_d;
   logic [15:0] data_in_q, data_in_d;
   logic [15:0] rd_cnt_q, rd_cnt_d;
   logic [15:0] wr_cnt_q, wr_cnt_d;
   logic        err_q, err_d;

   logic [15:0] mem [0:(1<<DEPTH_LOG2)-1];
   logic [DEPTH_LOG2-1:0] mem_addr;
   logic addr_oob;
   logic mem_we;
   logic rd_start, wr_start, conflict;

   assign mem_addr = Addr[DEPTH_LOG2-1:0];

`ifdef MEM_BOUNDS_EN
   assign addr_oob = (Addr >> DEPTH_LOG2) != 16'd0;
`else
   logic unused_addr_hi;
   assign unused_addr_hi = |(Addr >> DEPTH_LOG2);
   assign addr_oob = 1'b0;
`endif

   always_ff @(posedge Clk1) begin
      if (Reset) begin
         state_q   <= IDLE;
         data_in_q <= 16'h0000;
         rd_cnt_q  <= 16'h0000;
         wr_cnt_q  <= 16'h0000;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_in_q <= data_in_d;
         rd_cnt_q  <= rd_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         err_q     <= err_d;
      end
   end

   // Memory is deliberately not reset; Reset only suppresses a same-edge write.
   always_ff @(posedge Clk1) begin
      if (mem_we && !Reset) begin
         mem[mem_addr] <= DataOut;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (RD && WR)      state_d = CONFLICT;
            else if (RD)       state_d = RD_ACT;
            else if (WR)       state_d = WR_ACT;
         end
         RD_ACT: begin
            if (WR)            state_d = CONFLICT;
            else if (!RD)      state_d = IDLE;
         end
         WR_ACT: begin
            if (RD)            state_d = CONFLICT;
            else if (!WR)      state_d = IDLE;
         end
         CONFLICT: begin
            if (!RD && !WR)    state_d = IDLE;
         end
         default:              state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_start  = (state_q == IDLE) && RD && !WR;
      wr_start  = (state_q == IDLE) && WR && !RD;
      conflict  = ((state_q == IDLE) && RD && WR) ||
                  ((state_q == RD_ACT) && WR) ||
                  ((state_q == WR_ACT) && RD);
      data_in_d = data_in_q;
      rd_cnt_d  = rd_cnt_q;
      wr_cnt_d  = wr_cnt_q;
      err_d     = err_q;
      mem_we    = 1'b0;
      if (rd_start) begin
         if (addr_oob) begin
            data_in_d = BAD_DATA;
            err_d     = 1'b1;
         end else begin
            data_in_d = mem[mem_addr];
            if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
         end
      end
      if (wr_start) begin
         if (addr_oob) begin
            err_d = 1'b1;
         end else begin
            mem_we = 1'b1;
            if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
         end
      end
      if (conflict) err_d = 1'b1;
   end

   assign DataIn = data_in_q;
   assign Err    = err_q;
   assign Busy   = (state_q != IDLE);
   assign RdCnt  = rd_cnt_q;
   assign WrCnt  = wr_cnt_q;

endmodule

// File: doc/sys_mem_resp.md
# sys_mem_resp

System-memory responder for the CVP14 processor bus. It is the target end of the Addr/RD/WR/DataOut/DataIn interface that the core drives. It decodes single-word read and write requests and returns read data on DataIn. It tracks each request with a small handshake FSM, so a level held for several cycles performs exactly one access. It sits beside the core in the top level and also serves as the memory model in core-level benches.

## Interface
Parameters:
- DEPTH_LOG2, 10: log2 of word count; legal range 4..16; array holds 2**DEPTH_LOG2 16-bit words.
- BAD_DATA, 16'hDEAD: value returned on an errored read.

Ports:
- Clk1  in  1  clock; all state updates on posedge.
- Reset  in  1  reset Reset, synchronous, active-high; clock Clk1.
- Addr  in  16  word address from the core.
- RD  in  1  read request level, from the core.
- WR  in  1  write request level, from the core.
- DataOut  in  16  write data from the core (the core's DataOut).
- DataIn  out  16  read data to the core (the core's DataIn).
- Err  out  1  sticky protocol/address error flag.
- Busy  out  1  high while a request is being held (state not IDLE).
- RdCnt  out  16  completed reads, saturating at 16'hFFFF.
- WrCnt  out  16  completed writes, saturating at 16'hFFFF.

## Operation
- FSM states are IDLE, RD_ACT, WR_ACT and CONFLICT. All transitions happen on posedge Clk1.
- IDLE with RD=1, WR=0:
  - DataIn <= mem[Addr]; RdCnt++.
  - Next state RD_ACT.
- IDLE with WR=1, RD=0:
  - mem[Addr] <= DataOut; WrCnt++.
  - Next state WR_ACT.
- IDLE with RD=1, WR=1:
  - No access; Err <= 1.
  - Next state CONFLICT.
- RD_ACT:
  - Stays while RD=1, with no further reads and DataIn unchanged.
  - RD=0 returns to IDLE.
  - WR=1 in this state is a conflict: Err <= 1, next state CONFLICT.
- WR_ACT:
  - Stays while WR=1, with no rewrite.
  - WR=0 returns to IDLE.
  - RD=1 in this state is a conflict: Err <= 1, next state CONFLICT.
- CONFLICT: stays until RD=0 and WR=0 on the same edge, then returns to IDLE.
- DataIn holds the last read value until the next read completes.
- Addr and DataOut are sampled only on the edge that starts an access. Later changes during RD_ACT/WR_ACT are ignored.
- Counters saturate and do not wrap.
- Busy = (state != IDLE).

## Timing
- Read latency: DataIn is valid after the first posedge Clk1 that samples RD=1 in IDLE. The core's next Clk2 sample therefore sees the data.
- Write commits at the first posedge Clk1 that samples WR=1 in IDLE.
- Back-to-back accesses need at least one edge with the request low. Example: RD high, then low, then high gives two reads.
- Reset values: state IDLE, DataIn 16'h0000, Err 0, Busy 0, RdCnt 0, WrCnt 0.
- Memory contents are not reset.
- Reset asserted on the same edge as a request: Reset wins; no access; counters stay 0.
- Reset mid-access (RD_ACT/WR_ACT/CONFLICT) returns to IDLE. A request still held after Reset deasserts is treated as a new access.
- Err clears only on Reset.

## Configuration
- MEM_BOUNDS_EN defined:
  - Addr >= 2**DEPTH_LOG2 in IDLE is out of range.
  - Out-of-range read returns BAD_DATA on DataIn, sets Err, does not increment RdCnt, and enters RD_ACT.
  - Out-of-range write is dropped, sets Err, does not increment WrCnt, and enters WR_ACT.
- MEM_BOUNDS_EN undefined: Addr is truncated to Addr[DEPTH_LOG2-1:0], so high addresses alias. Err is set only by conflicts.

## Test plan
- Reset then write/read: WR=1, Addr=16'h0005, DataOut=16'hBEEF for 3 edges, then WR=0; then RD=1 for 2 edges at Addr 5 -> DataIn=16'hBEEF after first RD edge, WrCnt=1, RdCnt=1, Err=0.
- Held request: RD=1 for 5 edges while Addr changes 5->6 -> DataIn stays mem[5], RdCnt=1, Busy=1 throughout, Busy=0 the edge after RD drops.
- Conflict: RD=1, WR=1 together at Addr 3 holding 16'h1234, DataOut=16'h0000 -> mem[3] still 16'h1234, Err=1, state CONFLICT until both low; Err persists until Reset.
- Reset mid-write: WR=1 at Addr 7 with Reset=1 on the same edge -> mem[7] unchanged, WrCnt=0. Release Reset with WR still 1 -> one write, WrCnt=1.
- Bounds (DEPTH_LOG2=4), with MEM_BOUNDS_EN: read Addr 16'h0012 -> DataIn=16'hDEAD, Err=1. Without the macro: DataIn=mem[2], Err=0.
- Saturation: preload RdCnt near max via 65536 read pulses -> RdCnt=16'hFFFF and stays there on the next read.
